mult_share_arbiter: RTL and testbench

- Shares one nibble-serial unsigned multiplier (16-bit Mult × 4-bit Mcand → 20-bit product) between NREQ requesters.
- Round-robin arbitration, a valid/ready handshake per requester and on the output, and an internal Load / Add / Shift4 / Done sequencer that drives the accumulator datapath.
- Sits between client blocks and the shared arithmetic, replacing the single-user St/Done interface.

---
 rtl/mult_share_arbiter_if.sv | 28 ++
 rtl/mult_share_arbiter.sv | 157 +++++++++++++++
 tb/tb_mult_share_arbiter.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/mult_share_arbiter_if.sv
// mult_share_arbiter_if: request/result bus for the shared nibble-serial
// multiplier. The arbiter uses the slave modport, clients the master one.
interface mult_share_arbiter_if #(
  parameter int NREQ   = 4,
  parameter int MULT_W = 16
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ*MULT_W-1:0] req_mult;
  logic [NREQ*4-1:0]      req_mcand;
  logic                   out_valid;
  logic                   out_ready;
  logic [MULT_W+3:0]      out_product;
  logic [IDW-1:0]         out_id;
  logic                   busy;

  modport slave (
    input  req_valid, req_mult, req_mcand, out_ready,
    output req_ready, out_valid, out_product, out_id, busy
  );

  modport master (
    output req_valid, req_mult, req_mcand, out_ready,
    input  req_ready, out_valid, out_product, out_id, busy
  );
endinterface

// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: one nibble-serial unsigned multiplier (MULT_W x 4)
// shared between NREQ requesters with round-robin arbitration.
// The accumulator is MULT_W+8 bits: the top byte collects mcand * nibble,
// then the whole word shifts right four bits per multiplier nibble.
// Optional feature: define MULT_SHARE_ZERO_SKIP_EN to finish immediately
// (IDLE -> DONE, product 0) when either granted operand is zero.
module mult_share_arbiter #(
  parameter int NREQ   = 4,
  parameter int MULT_W = 16
) (
  input  logic                  clock,
  input  logic                  reset_n,
  mult_share_arbiter_if.slave   bus
);
  localparam int IDW   = $clog2(NREQ);
  localparam int STEPS = MULT_W / 4;
  localparam int SW    = $clog2(STEPS) + 1;
  localparam int ACC_W = MULT_W + 8;
  localparam logic [SW-1:0]  LAST_STEP = SW'(STEPS - 1);
  localparam logic [IDW-1:0] LAST_REQ  = IDW'(NREQ - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ADD   = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [ACC_W-1:0]   r_acc;
  logic [3:0]         r_mcand;
  logic [IDW-1:0]     r_id;
  logic [IDW-1:0]     r_ptr;
  logic [SW-1:0]      r_step;

  logic               w_found;
  logic [IDW-1:0]     w_grant_idx;
  logic [IDW-1:0]     w_scan_idx;
  logic [NREQ-1:0]    w_req_ready;
  logic [MULT_W-1:0]  w_mult_arr [NREQ];
  logic [3:0]         w_mcand_arr [NREQ];
  logic [7:0]         w_add_sum;
  logic               w_zero_op;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign w_mult_arr[gi]  = bus.req_mult[gi*MULT_W +: MULT_W];
    assign w_mcand_arr[gi] = bus.req_mcand[gi*4 +: 4];
  end

  // Top byte plus mcand times the current low nibble; bounded below 256.
  assign w_add_sum = r_acc[ACC_W-1 -: 8] + ({4'b0, r_mcand} * {4'b0, r_acc[3:0]});

`ifdef MULT_SHARE_ZERO_SKIP_EN
  assign w_zero_op = (w_mult_arr[w_grant_idx] == '0) || (w_mcand_arr[w_grant_idx] == 4'h0);
`else
  assign w_zero_op = 1'b0;
`endif

  // Round-robin scan: first valid requester after the last grant, wrapping.
  always_comb begin
    w_found     = 1'b0;
    w_grant_idx = '0;
    w_scan_idx  = r_ptr;
    for (int k = 0; k < NREQ; k++) begin
      if (w_scan_idx == LAST_REQ) begin
        w_scan_idx = '0;
      end else begin
        w_scan_idx = w_scan_idx + IDW'(1);
      end
      if (!w_found && bus.req_valid[w_scan_idx]) begin
        w_found     = 1'b1;
        w_grant_idx = w_scan_idx;
      end else begin
        w_found     = w_found;
      end
    end
  end

  // One-hot ready, only while idle and out of reset.
  always_comb begin
    w_req_ready = '0;
    if (reset_n && (r_state == S_IDLE) && w_found) begin
      w_req_ready[w_grant_idx] = 1'b1;
    end else begin
      w_req_ready = '0;
    end
  end

  // Sequencer next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_next_state = w_zero_op ? S_DONE : S_ADD;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_ADD:   w_next_state = S_SHIFT;
      S_SHIFT: begin
        if (r_step == LAST_STEP) begin
          w_next_state = S_DONE;
        end else begin
          w_next_state = S_ADD;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          w_next_state = S_IDLE;
        end else begin
          w_next_state = S_DONE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // State register, operand capture and accumulator datapath.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_mcand <= 4'h0;
      r_id    <= '0;
      r_ptr   <= LAST_REQ;
      r_step  <= '0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_acc   <= w_zero_op ? '0 : {8'b0, w_mult_arr[w_grant_idx]};
            r_mcand <= w_mcand_arr[w_grant_idx];
            r_id    <= w_grant_idx;
            r_ptr   <= w_grant_idx;
            r_step  <= '0;
          end
        end
        S_ADD: r_acc <= {w_add_sum, r_acc[MULT_W-1:0]};
        S_SHIFT: begin
          r_acc  <= r_acc >> 4;
          r_step <= r_step + SW'(1);
        end
        S_DONE:  r_acc <= r_acc;
        default: r_acc <= r_acc;
      endcase
    end
  end

  assign bus.req_ready   = w_req_ready;
  assign bus.out_valid   = (r_state == S_DONE);
  assign bus.out_product = r_acc[MULT_W+3:0];
  assign bus.out_id      = r_id;
  assign bus.busy        = (r_state != S_IDLE);
endmodule

// File: tb/tb_mult_share_arbiter.sv
// tb_mult_share_arbiter: directed vectors with hand-computed products for
// the shared multiplier arbiter (NREQ=4, MULT_W=16).
module tb_mult_share_arbiter;
  localparam int NREQ   = 4;
  localparam int MULT_W = 16;
`ifdef MULT_SHARE_ZERO_SKIP_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = 9;
`endif

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  mult_share_arbiter_if #(.NREQ(NREQ), .MULT_W(MULT_W)) bus ();

  mult_share_arbiter #(.NREQ(NREQ), .MULT_W(MULT_W)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input int i, input logic [15:0] m, input logic [3:0] c);
    bus.req_mult[i*16 +: 16] = m;
    bus.req_mcand[i*4 +: 4]  = c;
  endtask

  // Cycles from the grant edge until out_valid, bounded.
  task automatic wait_out(output int lat);
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic single(input string tag, input int i, input logic [15:0] m,
                        input logic [3:0] c, input logic [19:0] exp_p, input int exp_lat);
    int lat;
    set_req(i, m, c);
    bus.req_valid = 4'b0001 << i;
    #1;
    check({tag, "_ready"}, bus.req_ready, 4'b0001 << i);
    tick();
    bus.req_valid = '0;
    check({tag, "_ready_drop"}, bus.req_ready, 0);
    wait_out(lat);
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_product"}, bus.out_product, exp_p);
    check({tag, "_id"}, bus.out_id, i);
    tick();
    check({tag, "_valid_clr"}, bus.out_valid, 0);
    check({tag, "_busy_clr"}, bus.busy, 0);
  endtask

  logic [19:0] rr_prod [4];
  int          rr_id   [5];

  initial begin
    int lat;
    int seen;
    rr_prod = '{20'h0369C, 20'h001FE, 20'h40000, 20'h05555};
    rr_id   = '{0, 1, 2, 3, 0};
    bus.req_valid = '0;
    bus.req_mult  = '0;
    bus.req_mcand = '0;
    bus.out_ready = 1'b1;

    // Reset values
    repeat (2) tick();
    check("rst_valid", bus.out_valid, 0);
    check("rst_product", bus.out_product, 0);
    check("rst_id", bus.out_id, 0);
    check("rst_ready", bus.req_ready, 0);
    check("rst_busy", bus.busy, 0);
    reset_n = 1'b1;
    tick();

    // Single operations
    single("abcd", 0, 16'hABCD, 4'hF, 20'hA1103, 9);
    single("max", 2, 16'hFFFF, 4'hF, 20'hEFFF1, 9);
    single("one", 1, 16'h0001, 4'h1, 20'h00001, 9);

    // Round robin with all requesters valid, pointer freshly reset
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    set_req(0, 16'h1234, 4'h3);
    set_req(1, 16'h00FF, 4'h2);
    set_req(2, 16'h8000, 4'h8);
    set_req(3, 16'h1111, 4'h5);
    bus.req_valid = 4'b1111;
    #1;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("rr%0d_grant", k), bus.req_ready, 4'b0001 << rr_id[k]);
      tick();
      if (k == 4) bus.req_valid = '0;
      wait_out(lat);
      check($sformatf("rr%0d_latency", k), lat, 9);
      check($sformatf("rr%0d_product", k), bus.out_product, rr_prod[rr_id[k]]);
      check($sformatf("rr%0d_id", k), bus.out_id, rr_id[k]);
      tick();
    end

    // Backpressure: hold out_ready low for five cycles
    set_req(1, 16'h0F0F, 4'h3);
    bus.req_valid = 4'b0010;
    bus.out_ready = 1'b0;
    #1;
    check("bp_grant", bus.req_ready, 4'b0010);
    tick();
    bus.req_valid = 4'b1111;
    wait_out(lat);
    check("bp_latency", lat, 9);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp%0d_valid", k), bus.out_valid, 1);
      check($sformatf("bp%0d_product", k), bus.out_product, 20'h02D2D);
      check($sformatf("bp%0d_id", k), bus.out_id, 1);
      check($sformatf("bp%0d_ready", k), bus.req_ready, 0);
      check($sformatf("bp%0d_busy", k), bus.busy, 1);
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    check("bp_one_hs", bus.out_valid, 0);
    bus.req_valid = '0;
    tick();
    check("bp_no_second", bus.out_valid, 0);
    check("bp_idle", bus.busy, 0);

    // Reset during the third SHIFT discards the operation
    set_req(2, 16'h1234, 4'h3);
    bus.req_valid = 4'b0100;
    #1;
    check("mr_grant", bus.req_ready, 4'b0100);
    tick();
    bus.req_valid = '0;
    repeat (5) tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("mr_valid", bus.out_valid, 0);
    check("mr_product", bus.out_product, 0);
    check("mr_id", bus.out_id, 0);
    check("mr_busy", bus.busy, 0);
    check("mr_ready", bus.req_ready, 0);
    seen = 0;
    repeat (15) begin
      tick();
      if (bus.out_valid) seen = 1;
    end
    check("mr_no_partial", seen, 0);

    // Pointer reset: requester 0 wins over requester 3
    set_req(0, 16'h0002, 4'h4);
    set_req(3, 16'h0003, 4'h5);
    bus.req_valid = 4'b1001;
    #1;
    check("ptr_first", bus.req_ready, 4'b0001);
    tick();
    bus.req_valid = 4'b1000;
    wait_out(lat);
    check("ptr_p0", bus.out_product, 20'h00008);
    check("ptr_id0", bus.out_id, 0);
    tick();
    check("ptr_second", bus.req_ready, 4'b1000);
    tick();
    bus.req_valid = '0;
    wait_out(lat);
    check("ptr_p3", bus.out_product, 20'h0000F);
    check("ptr_id3", bus.out_id, 3);
    tick();

    // Zero multiplicand
    single("zero", 0, 16'h1234, 4'h0, 20'h00000, ZLAT);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
